// File: rtl/press_classifier.sv
// Classifies debounced button activity into short, long and double presses.
// Event pulses pass through one extra register stage so they land one edge after the deciding edge.
module press_classifier #(
   parameter int CNT_W       = 24,
   parameter int LONG_CYCLES = 12_000_000,
   parameter int GAP_CYCLES  = 3_000_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_pb_down,
   input  logic i_pb_up,
   output logic o_short_press,
   output logic o_long_press,
   output logic o_double_press,
   output logic o_busy
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      HOLD1    = 3'd1,
      LONGWAIT = 3'd2,
      GAP      = 3'd3,
      HOLD2    = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             r_evt_short;
   logic             r_evt_long;
   logic             r_evt_double;
   logic             w_evt_short;
   logic             w_evt_long;
   logic             w_evt_double;
   logic             r_short_press;
   logic             r_long_press;
   logic             r_double_press;
   logic             r_busy;
   logic             w_down;
   logic             w_up;

   // A simultaneous press and release is treated as no edge at all.
   assign w_down = i_pb_down & ~i_pb_up;
   assign w_up   = i_pb_up & ~i_pb_down;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_evt_short  = 1'b0;
      w_evt_long   = 1'b0;
      w_evt_double = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_next = '0;
            if (w_down) w_state_next = HOLD1;
         end
         HOLD1: begin
            if (w_up) begin
               w_state_next = GAP;
               w_cnt_next   = '0;
            end else if (r_cnt == LONG_LAST) begin
               w_state_next = LONGWAIT;
               w_cnt_next   = '0;
               w_evt_long   = 1'b1;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         LONGWAIT: begin
            w_cnt_next = '0;
            if (w_up) w_state_next = IDLE;
         end
         GAP: begin
            if (w_down) begin
               w_state_next = HOLD2;
               w_cnt_next   = '0;
            end else if (r_cnt == GAP_LAST) begin
               w_state_next = IDLE;
               w_cnt_next   = '0;
               w_evt_short  = 1'b1;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         HOLD2: begin
            w_cnt_next = '0;
            if (w_up) begin
               w_state_next = IDLE;
               w_evt_double = 1'b1;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
         end
      endcase
      if (!i_en) begin
         w_state_next = IDLE;
         w_cnt_next   = '0;
         w_evt_short  = 1'b0;
         w_evt_long   = 1'b0;
         w_evt_double = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_evt_short    <= 1'b0;
         r_evt_long     <= 1'b0;
         r_evt_double   <= 1'b0;
         r_short_press  <= 1'b0;
         r_long_press   <= 1'b0;
         r_double_press <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_cnt          <= w_cnt_next;
         r_evt_short    <= w_evt_short;
         r_evt_long     <= w_evt_long;
         r_evt_double   <= w_evt_double;
         // A pending pulse is dropped if enable falls on the edge it would appear.
         r_short_press  <= r_evt_short & i_en;
         r_long_press   <= r_evt_long & i_en;
         r_double_press <= r_evt_double & i_en;
         r_busy         <= (r_state != IDLE) | r_evt_short | r_evt_long | r_evt_double;
      end
   end

   assign o_short_press  = r_short_press;
   assign o_long_press   = r_long_press;
   assign o_double_press = r_double_press;
   assign o_busy         = r_busy;

endmodule

// File: tb/tb_press_classifier.sv
// Scenario-driven bench: each edge pushes the expected {short,long,double,busy} and pops it after the edge.
module tb_press_classifier;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en = 1'b1;
   logic pb_down = 1'b0;
   logic pb_up = 1'b0;
   logic short_press, long_press, double_press, busy;

   int n_checks = 0;
   int n_errors = 0;
   logic [3:0] exp_q[$];

   press_classifier #(.CNT_W(8), .LONG_CYCLES(8), .GAP_CYCLES(5)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_en(en),
      .i_pb_down(pb_down),
      .i_pb_up(pb_up),
      .o_short_press(short_press),
      .o_long_press(long_press),
      .o_double_press(double_press),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Edge k of a scenario is the k-th rising edge after the scenario starts.
   task automatic run_scn(input string name, input int n,
                          input logic [63:0] dn, input logic [63:0] up, input logic [63:0] en_lo,
                          input int rst_at, input int s_at, input int l_at, input int d_at,
                          input int b_lo, input int b_hi);
      logic [3:0] exp_v;
      logic [3:0] got_v;
      for (int k = 0; k < n; k++) begin
         pb_down = dn[k];
         pb_up   = up[k];
         en      = ~en_lo[k];
         if (k >= rst_at) exp_v = 4'b0000;
         else exp_v = {k == s_at, k == l_at, k == d_at, (k >= b_lo) && (k <= b_hi)};
         exp_q.push_back(exp_v);
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
            chk($sformatf("%s async_rst_outputs", name),
                {28'd0, short_press, long_press, double_press, busy}, 32'd0);
         end
         @(posedge clk);
         #1;
         rst = 1'b0;
         got_v = {short_press, long_press, double_press, busy};
         exp_v = exp_q.pop_front();
         $display("%s edge %0d: dn=%b up=%b en=%b out=%b exp=%b", name, k, dn[k], up[k], ~en_lo[k], got_v, exp_v);
         chk($sformatf("%s edge%0d {s,l,d,busy}", name, k), {28'd0, got_v}, {28'd0, exp_v});
      end
      pb_down = 1'b0;
      pb_up   = 1'b0;
      en      = 1'b1;
   endtask

   localparam int NO = 1000;

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("reset_state", {28'd0, short_press, long_press, double_press, busy}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;

      // short press: down 0, up 3 -> short at 9, busy 1..9
      run_scn("short", 14, 64'h1, 64'h8, 64'h0, NO, 9, NO, NO, 1, 9);
      // long press: down 0, up 20 -> long at 9, busy low from 21
      run_scn("long", 24, 64'h1, 64'h1 << 20, 64'h0, NO, NO, 9, NO, 1, 20);
      // double press: down 0,5 up 2,30 -> double at 31
      run_scn("double", 35, 64'h21, (64'h1 << 30) | 64'h4, 64'h0, NO, NO, NO, 31, 1, 31);
      // gap race: up 2, down at counter match 7 -> HOLD2, then up 12 -> double 13
      run_scn("gap_race", 16, 64'h81, 64'h1004, 64'h0, NO, NO, NO, 13, 1, 13);
      // hold1 race: up at match edge 8 -> no long, short at 14
      run_scn("hold1_race", 18, 64'h1, 64'h100, 64'h0, NO, 14, NO, NO, 1, 14);
      // simultaneous down+up at 3 ignored, real up at 5 -> short at 11
      run_scn("both_high", 15, 64'h9, 64'h28, 64'h0, NO, 11, NO, NO, 1, 11);
      // enable low at edge 4, up at 6 -> no pulse, busy low from 5
      run_scn("en_drop", 12, 64'h1, 64'h40, 64'h10, NO, NO, NO, NO, 1, 4);
      // reset at edge 4, up at 6 -> no pulse, outputs 0 immediately
      run_scn("rst_mid", 12, 64'h1, 64'h40, 64'h0, 4, NO, NO, NO, 1, 3);
      // first edge after reset release reacts: short press again
      run_scn("post_rst", 12, 64'h1, 64'h4, 64'h0, NO, 8, NO, NO, 1, 8);

      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
